icache_dm: RTL
==============

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the core's instruction fetch port (inst_ren/inst_addr/inst_data) and a slower word-wide backing instruction memory.
- Serves hits in the same cycle. Stalls the core on a miss and refills one whole line over a req/ack handshake.
- Provides a flush input for self-modifying code or a program reload, plus a saturating miss counter for the debug readout.

Parameters:
- LINE_WORDS, 4, words per line (power of two, >=2).
- LINES, 16, number of lines (power of two).
- CNT_WIDTH, 16, width of the saturating miss counter.

Ports:
- clk  input  1  main clock
- rst  input  1  reset, asynchronous, active-high
- inst_ren  input  1  fetch request from the core
- inst_addr  input  32  byte address of the fetch; bits [1:0] ignored
- inst_data  output  32  instruction word; valid when inst_ren=1 and stall=0
- stall  output  1  core must hold the PC and IF/ID register while this is high
- flush  input  1  invalidate all lines
- mem_req  output  1  backing-memory word read request
- mem_addr  output  32  word-aligned backing-memory address
- mem_ack  input  1  backing memory returns mem_rdata this cycle
- mem_rdata  input  32  backing-memory read data
- miss_count  output  CNT_WIDTH  saturating count of misses since reset

Behaviour:
- Address split, with defaults in brackets:
  - offset = addr[2+log2(LINE_WORDS)-1:2] [3:2]
  - index = next log2(LINES) bits [7:4]
  - tag = remaining upper bits [31:8]
- Storage:
  - Data array of LINES*LINE_WORDS words, registers.
  - Tag array and valid bit per line.
  - Reads are combinational.
  - Writes occur on the clk rising edge.
- Reset (asynchronous):
  - All valid bits = 0.
  - FSM state = IDLE; stall=0, mem_req=0, mem_addr=0, miss_count=0, inst_data=0.
  - The data and tag arrays are not reset.
- hit = inst_ren & valid[index] & (tag_array[index]==tag).
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - hit: inst_data = word at offset, stall=0, same cycle.
  - inst_ren=0: stall=0 and inst_data=0.
  - inst_ren & !hit: stall=1 combinationally this cycle. Next edge: latch the miss tag/index, word counter=0, increment miss_count unless saturated, go to FILL.
- FILL:
  - mem_req=1 and mem_addr={tag,index,counter,2'b00}.
  - mem_req and mem_addr must stay stable until mem_ack is sampled high.
  - On ack: write mem_rdata into the data array at [index][counter], then counter++.
  - On the ack of word LINE_WORDS-1: go to DONE.
  - At most one word is outstanding. mem_req may stay high back-to-back, one word per ack.
  - stall=1 throughout.
- DONE:
  - Write the tag and set valid[index]=1, unless the fill was poisoned. stall=1, mem_req=0.
  - Next state is IDLE, where the refetch hits (miss-to-data penalty = LINE_WORDS acks + 2 cycles).
- The core holds inst_addr constant while stall=1. The cache uses the latched miss address, not live inst_addr, during FILL/DONE.
- flush:
  - In IDLE: all valid bits cleared at the next edge, and hit is forced to 0 in the flush cycle.
  - During FILL/DONE: valid bits cleared, a poison flag is set, and the fill continues to completion so no handshake is abandoned. DONE then does not set valid, and the refetch misses again.
  - A flush and a miss in the same IDLE cycle: the miss is taken, and the new line is valid after the fill.
- miss_count saturates at all-ones and does not wrap.
- Reset mid-FILL: mem_req drops immediately (asynchronous). The backing memory must tolerate an abandoned request.

Test Plan:
1. Cold miss: after reset, inst_ren=1, inst_addr=0x0000_0004; memory acks 1 cycle after each req with data 0x100+word:
   - mem_addr sequence 0x0, 0x4, 0x8, 0xC.
   - stall high until the refetch; inst_data=0x101; miss_count=1.
2. Hit sweep: after case 1, fetch 0x0, 0x8, 0xC on consecutive cycles -> stall=0 each cycle; data 0x100, 0x102, 0x103; miss_count stays 1.
3. Conflict eviction: fetch 0x100 (same index 0, tag 1) -> new fill, miss_count=2. Then fetch 0x0 -> misses again, miss_count=3.
4. Slow memory: mem_ack delayed 5 cycles per word -> mem_req/mem_addr held constant for 5 cycles per word; no duplicate array writes; total stall = 4*6+2 cycles.
5. Flush mid-fill: assert flush one cycle during the second word of the fill for 0x40:
   - All 4 acks are consumed.
   - The refetch of 0x40 misses again, miss_count increments.
   - Previously cached 0x0 also misses.
6. Async reset during FILL: assert rst between cycles -> mem_req=0 and stall=0 before the next edge. After release, fetch 0x0 misses and miss_count restarts at 1.

Source files
------------

// File: rtl/icache_dm_if.sv
// Word-wide read bus between the instruction cache (master) and backing memory (slave).
// Handshake: mem_req/mem_addr are held stable until mem_ack is sampled high on a rising
// edge; each ack completes exactly one word, with mem_rdata valid in the ack cycle.
interface icache_dm_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits, whole-line refill on a miss,
// flush with fill poisoning, and a saturating miss counter.
module icache_dm #(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_ren,
  input  logic [31:0]          inst_addr,
  output logic [31:0]          inst_data,
  output logic                 stall,
  input  logic                 flush,
  icache_dm_if.master          mem,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [1:0]           dbg_state
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_DONE = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [TAG_W-1:0]       miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]       miss_idx_q, miss_idx_d;
  logic [OFF_W-1:0]       cnt_q, cnt_d;
  logic                   poison_q, poison_d;
  logic [CNT_WIDTH-1:0]   miss_count_q, miss_count_d;
  logic [LINES-1:0]       valid_q, valid_d;

  logic [31:0]            data_q [LINES*LINE_WORDS];
  logic [TAG_W-1:0]       tag_q  [LINES];

  logic [OFF_W-1:0]       a_off;
  logic [IDX_W-1:0]       a_idx;
  logic [TAG_W-1:0]       a_tag;
  logic                   hit;
  logic                   data_we, tag_we;
  logic                   stall_c, mem_req_c;
  logic [31:0]            mem_addr_c;

  assign a_off = inst_addr[2 +: OFF_W];
  assign a_idx = inst_addr[2+OFF_W +: IDX_W];
  assign a_tag = inst_addr[31 -: TAG_W];
  // A flush cycle never hits, so the core cannot read a line that is being invalidated.
  assign hit   = inst_ren & valid_q[a_idx] & (tag_q[a_idx] == a_tag) & ~flush;

  always_comb begin
    state_d      = state_q;
    miss_tag_d   = miss_tag_q;
    miss_idx_d   = miss_idx_q;
    cnt_d        = cnt_q;
    poison_d     = poison_q;
    miss_count_d = miss_count_q;
    valid_d      = valid_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    stall_c      = 1'b0;
    inst_data    = '0;
    mem_req_c    = 1'b0;
    mem_addr_c   = '0;
    case (state_q)
      S_IDLE: begin
        if (flush) valid_d = '0;
        if (hit) begin
          inst_data = data_q[{a_idx, a_off}];
        end else if (inst_ren) begin
          stall_c    = 1'b1;
          state_d    = S_FILL;
          miss_tag_d = a_tag;
          miss_idx_d = a_idx;
          cnt_d      = '0;
          poison_d   = 1'b0;
          if (miss_count_q != '1) miss_count_d = miss_count_q + 1'b1;
        end
      end
      S_FILL: begin
        stall_c    = 1'b1;
        mem_req_c  = 1'b1;
        mem_addr_c = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
        if (mem.mem_ack) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) state_d = S_DONE;
        end
        // The fill keeps running after a flush; only its final install is cancelled.
        if (flush) begin
          valid_d  = '0;
          poison_d = 1'b1;
        end
      end
      S_DONE: begin
        stall_c = 1'b1;
        state_d = S_IDLE;
        if (!poison_q && !flush) begin
          tag_we              = 1'b1;
          valid_d[miss_idx_q] = 1'b1;
        end
        if (flush) valid_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      cnt_q        <= '0;
      poison_q     <= 1'b0;
      miss_count_q <= '0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      miss_tag_q   <= miss_tag_d;
      miss_idx_q   <= miss_idx_d;
      cnt_q        <= cnt_d;
      poison_q     <= poison_d;
      miss_count_q <= miss_count_d;
      valid_q      <= valid_d;
    end
  end

  // Storage arrays carry no reset; the valid bits alone decide what is usable.
  always_ff @(posedge clk) begin
    if (data_we) data_q[{miss_idx_q, cnt_q}] <= mem.mem_rdata;
    if (tag_we)  tag_q[miss_idx_q]           <= miss_tag_q;
  end

  assign stall        = stall_c & ~rst;
  assign mem.mem_req  = mem_req_c;
  assign mem.mem_addr = mem_addr_c;
  assign miss_count   = miss_count_q;
  assign dbg_state    = state_q;
endmodule
